// File: rtl/stream_demux_one_to_four.sv
// -----------------------------------------------------------------------------
// stream_demux_one_to_four
//
// Registered 1-to-4 stream demultiplexer. Each word accepted on the input
// stream lands in the one-entry holding register of one of four output
// channels. The target channel is SEL, or the internal round-robin pointer
// when RR_MODE=1. A stalled channel blocks only words aimed at it.
//
// Ports
//   clk         in   1          system clock, rising edge
//   rst         in   1          asynchronous, active-high reset
//   DIN         in   DATA_W     input data word
//   DIN_VALID   in   1          DIN/SEL hold a word to deliver
//   DIN_READY   out  1          block can take the word this cycle
//   SEL         in   2          target channel (ignored when RR_MODE=1)
//   RR_MODE     in   1          1 = target is RR_PTR, 0 = target is SEL
//   DOUT        out  4*DATA_W   channel k data = DOUT[k*DATA_W +: DATA_W]
//   DOUT_VALID  out  4          per-channel holding register full
//   DOUT_READY  in   4          per-channel consumer takes the word this cycle
//   RR_PTR      out  2          current round-robin pointer
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds its word stable (and keeps valid high) until that
// edge; ready may depend combinationally on the consumer side but never on
// valid, so no handshake loop exists.
// -----------------------------------------------------------------------------
module stream_demux_one_to_four #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   DIN,
  input  logic                DIN_VALID,
  output logic                DIN_READY,
  input  logic [1:0]          SEL,
  input  logic                RR_MODE,
  output logic [4*DATA_W-1:0] DOUT,
  output logic [3:0]          DOUT_VALID,
  input  logic [3:0]          DOUT_READY,
  output logic [1:0]          RR_PTR
);

  logic [1:0] tgt;
  logic       acc;
  logic [3:0] wr;     // one-hot: channel written at the coming edge
  logic [3:0] drain;  // channel handing its word to the consumer

  // Target is re-evaluated every cycle, so a stalled word follows SEL or
  // RR_MODE changes without any state update.
  always_comb begin
    tgt = RR_MODE ? RR_PTR : SEL;
  end

  // A channel can take a word if empty, or if it drains at this same edge
  // (full throughput on one channel).
  always_comb begin
    DIN_READY = ~rst & (~DOUT_VALID[tgt] | DOUT_READY[tgt]);
    acc       = DIN_VALID & DIN_READY;
  end

  always_comb begin
    wr    = 4'b0000;
    drain = DOUT_VALID & DOUT_READY;
    if (acc) begin
      wr[tgt] = 1'b1;
    end
  end

  // Holding registers. A write wins over a drain on the same channel, which
  // keeps valid high and replaces the data. Data is left untouched on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DOUT       <= '0;
      DOUT_VALID <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (wr[k]) begin
          DOUT[k*DATA_W +: DATA_W] <= DIN;
          DOUT_VALID[k]            <= 1'b1;
        end else if (drain[k]) begin
          DOUT_VALID[k]            <= 1'b0;
        end
      end
    end
  end

  // The pointer advances only on an accepted round-robin word, so it waits
  // on a full channel rather than skipping it, and holds across mode changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RR_PTR <= 2'd0;
    end else if (acc && RR_MODE) begin
      RR_PTR <= RR_PTR + 2'd1;
    end
  end

endmodule

// File: tb/tb_stream_demux_one_to_four.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_one_to_four
//
// Directed bench for stream_demux_one_to_four. Inputs change 1 time unit after
// a rising edge; outputs are sampled away from the edge. Expected values are
// hand-computed constants plus a small queue of words for the round-robin run.
// -----------------------------------------------------------------------------
module tb_stream_demux_one_to_four;

  localparam int DATA_W = 8;

  logic                clk;
  logic                rst;
  logic [DATA_W-1:0]   din;
  logic                din_valid;
  logic                din_ready;
  logic [1:0]          sel;
  logic                rr_mode;
  logic [4*DATA_W-1:0] dout;
  logic [3:0]          dout_valid;
  logic [3:0]          dout_ready;
  logic [1:0]          rr_ptr;

  int n_checks;
  int n_errors;

  logic [DATA_W-1:0] exp_q[$];

  stream_demux_one_to_four #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .DIN        (din),
    .DIN_VALID  (din_valid),
    .DIN_READY  (din_ready),
    .SEL        (sel),
    .RR_MODE    (rr_mode),
    .DOUT       (dout),
    .DOUT_VALID (dout_valid),
    .DOUT_READY (dout_ready),
    .RR_PTR     (rr_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] slice(input int k);
    return dout[k*DATA_W +: DATA_W];
  endfunction

  // drivers
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [DATA_W-1:0] d);
    din_valid = v;
    sel       = s;
    din       = d;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    sel        = 2'd0;
    rr_mode    = 1'b0;
    dout_ready = 4'b0000;

    // power-on reset
    #3;
    check("por_din_ready", din_ready, 0);
    check("por_valid", dout_valid, 0);
    check("por_dout", dout, 0);
    check("por_rr_ptr", rr_ptr, 0);
    #10;
    rst = 1'b0;
    cycle();

    // T2 directed routing, one word per cycle to channels 0..3
    dout_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 8'hA0 + 8'(k));
      #1;
      check($sformatf("t2_ready_%0d", k), din_ready, 1);
      cycle();
      check($sformatf("t2_valid_%0d", k), dout_valid, 32'(4'b0001 << k));
      check($sformatf("t2_data_%0d", k), slice(k), 8'hA0 + 8'(k));
    end
    drive(1'b0, 2'd0, 8'h00);
    cycle();
    check("t2_drained", dout_valid, 0);

    // T3 back-pressure on channel 2
    dout_ready = 4'b1011;
    drive(1'b1, 2'd2, 8'h11);
    #1;
    check("t3_ready_first", din_ready, 1);
    cycle();
    check("t3_valid_first", dout_valid, 4'b0100);
    check("t3_data_first", slice(2), 8'h11);
    drive(1'b1, 2'd2, 8'h22);
    #1;
    check("t3_ready_blocked", din_ready, 0);
    cycle();
    check("t3_held_data", slice(2), 8'h11);
    check("t3_held_valid", dout_valid, 4'b0100);
    dout_ready = 4'hF;
    #1;
    check("t3_ready_release", din_ready, 1);
    cycle();
    check("t3_data_second", slice(2), 8'h22);
    check("t3_valid_second", dout_valid, 4'b0100);
    drive(1'b0, 2'd0, 8'h00);
    cycle();
    check("t3_drained", dout_valid, 0);

    // T4 independence: channel 0 stalled does not block channel 1
    dout_ready = 4'b1110;
    drive(1'b1, 2'd0, 8'h44);
    cycle();
    check("t4_ch0_full", dout_valid, 4'b0001);
    drive(1'b1, 2'd1, 8'h55);
    #1;
    check("t4_ready_ch1", din_ready, 1);
    cycle();
    check("t4_valid", dout_valid, 4'b0011);
    check("t4_data_ch1", slice(1), 8'h55);
    check("t4_data_ch0", slice(0), 8'h44);
    drive(1'b0, 2'd0, 8'h00);
    cycle();
    check("t4_ch0_still", dout_valid, 4'b0001);
    dout_ready = 4'hF;
    cycle();
    check("t4_drained", dout_valid, 0);

    // T5 round-robin wrap
    rr_mode = 1'b1;
    check("t5_ptr_start", rr_ptr, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'd0, 8'(i));
      exp_q.push_back(8'(i));
      #1;
      check($sformatf("t5_ready_%0d", i), din_ready, 1);
      cycle();
      check($sformatf("t5_valid_%0d", i), dout_valid, 32'(4'b0001 << (i % 4)));
      check($sformatf("t5_data_%0d", i), slice(i % 4), exp_q.pop_front());
      check($sformatf("t5_ptr_%0d", i), rr_ptr, (i + 1) % 4);
    end
    drive(1'b0, 2'd0, 8'h00);
    cycle();
    check("t5_ptr_end", rr_ptr, 2);
    // fill channel 2 by SEL, then a round-robin word must stall on it
    dout_ready = 4'b1011;
    rr_mode    = 1'b0;
    drive(1'b1, 2'd2, 8'h06);
    cycle();
    check("t5_ch2_full", dout_valid, 4'b0100);
    check("t5_ptr_sel", rr_ptr, 2);
    rr_mode = 1'b1;
    drive(1'b1, 2'd0, 8'h07);
    #1;
    check("t5_stall_ready", din_ready, 0);
    cycle();
    cycle();
    check("t5_stall_ptr", rr_ptr, 2);
    check("t5_stall_data", slice(2), 8'h06);
    check("t5_stall_valid", dout_valid, 4'b0100);
    drive(1'b0, 2'd0, 8'h00);
    dout_ready = 4'hF;
    cycle();
    check("t5_drained", dout_valid, 0);

    // T6 mode switch keeps the pointer
    rr_mode = 1'b0;
    drive(1'b1, 2'd0, 8'h77);
    #1;
    check("t6_ready_sel", din_ready, 1);
    cycle();
    check("t6_valid_sel", dout_valid, 4'b0001);
    check("t6_data_sel", slice(0), 8'h77);
    check("t6_ptr_kept", rr_ptr, 2);
    rr_mode = 1'b1;
    drive(1'b1, 2'd0, 8'h88);
    cycle();
    check("t6_valid_rr", dout_valid, 4'b0100);
    check("t6_data_rr", slice(2), 8'h88);
    check("t6_ptr_adv", rr_ptr, 3);
    drive(1'b0, 2'd0, 8'h00);
    cycle();

    // T1 reset mid-traffic with channels 1 and 3 full
    rr_mode    = 1'b0;
    dout_ready = 4'b0101;
    drive(1'b1, 2'd1, 8'h66);
    cycle();
    drive(1'b1, 2'd3, 8'h99);
    cycle();
    drive(1'b1, 2'd0, 8'hAB);
    check("t1_pre_valid", dout_valid, 4'b1010);
    check("t1_pre_ptr", rr_ptr, 3);
    #2;
    rst = 1'b1;
    #1;
    check("t1_valid", dout_valid, 0);
    check("t1_dout", dout, 0);
    check("t1_ptr", rr_ptr, 0);
    check("t1_ready", din_ready, 0);
    cycle();
    check("t1_hold_valid", dout_valid, 0);
    drive(1'b0, 2'd0, 8'h00);
    #2;
    rst = 1'b0;
    cycle();
    check("t1_after_valid", dout_valid, 0);
    check("t1_after_dout", dout, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // safety bound
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
